// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART blocks.
//  - PAR_* : parity mode codes carried on parity_i
//  - state_e : transmitter FSM state encoding
//  - parity_en() : whether a parity mode inserts a parity bit
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] PAR_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // The reserved code behaves like "no parity".
  function automatic logic parity_en(input logic [1:0] mode);
    logic en;
    case (mode)
      PAR_ODD, PAR_EVEN: en = 1'b1;
      PAR_NONE, PAR_RSVD: en = 1'b0;
      default:            en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with show-ahead read data.
//  clk     in   clock
//  rst     in   synchronous active-high reset (flushes pointers)
//  push_i  in   write request; ignored while full (even if popping the same edge)
//  wdata_i in   DATA_W write data
//  pop_i   in   read request; ignored while empty
//  rdata_o out  DATA_W word at the head of the queue
//  full_o  out  DEPTH words held
//  empty_o out  no words held
//  level_o out  number of words held
module uart_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              push_ok;
  logic              pop_ok;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign level_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (push_ok) begin
      wptr_d = wptr_q + (AW+1)'(1);
      mem_d[wptr_q[AW-1:0]] = wdata_i;
    end
    if (pop_ok) begin
      rptr_d = rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is data only; a reset just flushes the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an input FIFO, clocked at the bit rate.
//  baud_clk in   bit-rate clock
//  rst      in   synchronous active-high reset
//  data_i   in   DATA_W word to queue
//  valid_i  in   data_i valid; accepted when valid_i && ready_o
//  ready_o  out  FIFO not full
//  parity_i in   00 none, 01 odd, 10 even, 11 none
//  stop2_i  in   0 one stop bit, 1 two stop bits
//  tx_o     out  serial line, idle high, registered
//  busy_o   out  frame in progress
//  level_o  out  words queued (excludes the word being shifted)
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     baud_clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [1:0]               parity_i,
  input  logic                     stop2_i,
  output logic                     tx_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d;
  logic              tx_q, tx_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_rdata;

  uart_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (baud_clk),
    .rst     (rst),
    .push_i  (valid_i),
    .wdata_i (data_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  assign ready_o = !fifo_full;
  assign busy_o  = (state_q != ST_IDLE);
  assign tx_o    = tx_q;

  // tx_d is the line level for the state being entered, so tx_o changes on
  // the same edge as the state register (start bit appears on the pop edge).
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    tx_d       = 1'b1;
    fifo_pop   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_rdata;
          par_en_d  = parity_en(parity_i);
          par_bit_d = (parity_i == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
          stop2_d   = stop2_i;
          state_d   = ST_START;
          tx_d      = 1'b0;
        end
      end

      ST_START: begin
        state_d = ST_DATA;
        cnt_d   = '0;
        tx_d    = shift_q[0];
      end

      ST_DATA: begin
        if (cnt_q == LAST_BIT) begin
          if (par_en_q) begin
            state_d = ST_PARITY;
            tx_d    = par_bit_q;
          end else begin
            state_d    = ST_STOP;
            stop_cnt_d = 1'b0;
            tx_d       = 1'b1;
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          shift_d = shift_q >> 1;
          tx_d    = shift_q[1];
        end
      end

      ST_PARITY: begin
        state_d    = ST_STOP;
        stop_cnt_d = 1'b0;
        tx_d       = 1'b1;
      end

      ST_STOP: begin
        if (stop_cnt_q == stop2_q) begin
          // Last stop bit: chain straight into the next frame when one is queued.
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_rdata;
            par_en_d  = parity_en(parity_i);
            par_bit_d = (parity_i == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
            stop2_d   = stop2_i;
            state_d   = ST_START;
            tx_d      = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          stop_cnt_d = 1'b1;
          tx_d       = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      stop_cnt_q <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
    end
  end

  always_ff @(posedge baud_clk) begin
    shift_q   <= shift_d;
    par_bit_q <= par_bit_d;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  logic       baud_clk;
  logic       rst;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic [1:0] parity_i;
  logic       stop2_i;
  logic       tx_o;
  logic       busy_o;
  logic [2:0] level_o;

  logic [4:0] data5;
  logic       valid5, ready5, tx5, busy5;
  logic [2:0] level5;
  logic [8:0] data9;
  logic       valid9, ready9, tx9, busy9;
  logic [2:0] level9;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_fifo #(.DATA_W(8), .DEPTH(4)) u_dut (
    .baud_clk (baud_clk), .rst (rst), .data_i (data_i), .valid_i (valid_i),
    .ready_o (ready_o), .parity_i (parity_i), .stop2_i (stop2_i),
    .tx_o (tx_o), .busy_o (busy_o), .level_o (level_o)
  );

  uart_tx_fifo #(.DATA_W(5), .DEPTH(4)) u_dut5 (
    .baud_clk (baud_clk), .rst (rst), .data_i (data5), .valid_i (valid5),
    .ready_o (ready5), .parity_i (parity_i), .stop2_i (stop2_i),
    .tx_o (tx5), .busy_o (busy5), .level_o (level5)
  );

  uart_tx_fifo #(.DATA_W(9), .DEPTH(4)) u_dut9 (
    .baud_clk (baud_clk), .rst (rst), .data_i (data9), .valid_i (valid9),
    .ready_o (ready9), .parity_i (parity_i), .stop2_i (stop2_i),
    .tx_o (tx9), .busy_o (busy9), .level_o (level9)
  );

  initial baud_clk = 1'b0;
  always #5 baud_clk = ~baud_clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge baud_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Queue one word on the 8-bit DUT and compare the line, first bit on line
  // in the MSB of exp. Optionally flip config mid-frame.
  task automatic send_frame(input string tag, input logic [7:0] d, input logic [1:0] par,
                            input logic s2, input logic [15:0] exp, input int len,
                            input bit toggle);
    logic [15:0] got;
    int          busy_n;
    data_i   = d;
    parity_i = par;
    stop2_i  = s2;
    valid_i  = 1'b1;
    tick;
    valid_i  = 1'b0;
    check({tag, "_e0"}, 64'(tx_o), 64'd1);
    got    = '0;
    busy_n = 0;
    for (int i = 0; i < len; i++) begin
      tick;
      got    = {got[14:0], tx_o};
      busy_n = busy_n + int'(busy_o);
      if (toggle && i == 3) begin
        stop2_i  = ~s2;
        parity_i = 2'b10;
      end
    end
    check(tag, 64'(got), 64'(exp));
    check({tag, "_busy"}, 64'(busy_n), 64'(len));
    tick;
    check({tag, "_end"}, 64'({tx_o, busy_o}), 64'(2'b10));
  endtask

  logic [7:0]  w4 [6];
  logic [63:0] stream;
  logic [11:0] got5, got9;
  int          guard;
  int          bad;
  int          b5, b9;

  initial begin
    w4 = '{8'h01, 8'h80, 8'hF0, 8'h3C, 8'hAA, 8'h55};
    rst = 1'b1; data_i = '0; valid_i = 1'b0; parity_i = 2'b00; stop2_i = 1'b0;
    data5 = '0; valid5 = 1'b0; data9 = '0; valid9 = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    check("rst_state", 64'({tx_o, busy_o, level_o, ready_o}), 64'({1'b1, 1'b0, 3'd0, 1'b1}));

    // 1..3: single frames
    send_frame("t1_aa_none",   8'hAA, 2'b00, 1'b0, 16'(10'b0010101011),  10, 1'b0);
    send_frame("t2_aa_even",   8'hAA, 2'b10, 1'b0, 16'(11'b00101010101), 11, 1'b0);
    send_frame("t2_aa_odd",    8'hAA, 2'b01, 1'b0, 16'(11'b00101010111), 11, 1'b0);
    send_frame("t2_07_odd",    8'h07, 2'b01, 1'b0, 16'(11'b01110000001), 11, 1'b0);
    send_frame("t2_aa_rsvd",   8'hAA, 2'b11, 1'b0, 16'(10'b0010101011),  10, 1'b0);
    send_frame("t3_aa_stop2",  8'hAA, 2'b00, 1'b1, 16'(11'b00101010111), 11, 1'b0);
    send_frame("t3_aa_toggle", 8'hAA, 2'b00, 1'b0, 16'(10'b0010101011),  10, 1'b1);

    // 4: fill the FIFO, back-to-back frames, order preserved
    parity_i = 2'b00;
    stop2_i  = 1'b0;
    stream   = '0;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          data_i  = w4[k];
          valid_i = 1'b1;
          guard   = 0;
          while (!ready_o && guard < 50) begin
            tick;
            guard++;
          end
          if (k == 5) check("t4_hold_cycles", 64'(guard), 64'd7);
          tick;
          if (k == 4) begin
            check("t4_level_full", 64'(level_o), 64'd4);
            check("t4_ready_low", 64'(ready_o), 64'd0);
          end
        end
        valid_i = 1'b0;
      end
      begin
        tick;
        for (int i = 0; i < 60; i++) begin
          tick;
          stream = {stream[62:0], tx_o};
        end
      end
    join
    check("t4_stream", stream, 64'({10'b0100000001, 10'b0000000011, 10'b0000011111,
                                    10'b0001111001, 10'b0010101011, 10'b0101010101}));
    tick;
    check("t4_end", 64'({tx_o, busy_o, level_o}), 64'({1'b1, 1'b0, 3'd0}));

    // 5: reset mid-DATA with two words queued
    data_i = 8'h55; valid_i = 1'b1;
    tick;
    data_i = 8'h11;
    tick;
    data_i = 8'h22;
    tick;
    valid_i = 1'b0;
    check("t5_level_q", 64'(level_o), 64'd2);
    tick;
    check("t5_pre_tx", 64'({tx_o, busy_o}), 64'(2'b01));
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("t5_rst", 64'({tx_o, busy_o, level_o, ready_o}), 64'({1'b1, 1'b0, 3'd0, 1'b1}));
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
    end
    check("t5_quiet", 64'(bad), 64'd0);

    // 6: 5-bit and 9-bit builds, even parity
    parity_i = 2'b10;
    stop2_i  = 1'b0;
    data5 = 5'h15; valid5 = 1'b1;
    data9 = 9'h1FF; valid9 = 1'b1;
    tick;
    valid5 = 1'b0;
    valid9 = 1'b0;
    got5 = '0; got9 = '0; b5 = 0; b9 = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      got5 = {got5[10:0], tx5};
      got9 = {got9[10:0], tx9};
      b5 = b5 + int'(busy5);
      b9 = b9 + int'(busy9);
    end
    check("t6_w5_frame", 64'(got5), 64'(12'b010101111111));
    check("t6_w9_frame", 64'(got9), 64'(12'b011111111111));
    check("t6_w5_busy", 64'(b5), 64'd8);
    check("t6_w9_busy", 64'(b9), 64'd12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
